led_pulse_gen: RTL and testbench

Output-side companion to the button input path. It converts single-cycle event strobes into LED pulses with a guaranteed minimum on-time and off-time, so every event is visible. Events that arrive while a pulse is in progress are queued in a saturating pending counter. It sits between the control logic (APB-side event strobes, debounced button edges) and the board LED pin.

---
 rtl/led_pulse_gen_pkg.sv | 15 +
 rtl/led_pulse_gen.sv | 103 ++++++++++
 tb/tb_led_pulse_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/led_pulse_gen_pkg.sv
// Shared FSM encoding and default timing for the LED pulse generator.
package led_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_ON_CYCLES  = 50000;
  localparam int DEF_OFF_CYCLES = 50000;
  localparam int DEF_PEND_W     = 4;

endpackage

// File: rtl/led_pulse_gen.sv
// Turns single-cycle event strobes into LED pulses with guaranteed on/off time,
// queueing events that arrive mid-pulse in a saturating pending counter.
module led_pulse_gen
  import led_pulse_gen_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ON_CYCLES  = DEF_ON_CYCLES,
  parameter int OFF_CYCLES = DEF_OFF_CYCLES,
  parameter int PEND_W     = DEF_PEND_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              clr,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] tmr;
  logic             pend_full;
  logic             pend_any;
  logic             tmr_done;

  assign pend_full = (pending == PEND_MAX);
  assign pend_any  = (pending != '0);
  assign tmr_done  = (tmr == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tmr      <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      state    <= IDLE;
      tmr      <= '0;
      led      <= 1'b0;
      busy     <= 1'b0;
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state <= ON;
            tmr   <= ON_LOAD;
            led   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ON: begin
          if (trig) begin
            if (pend_full) overflow <= 1'b1;
            else           pending  <= pending + 1'b1;
          end
          if (tmr_done) begin
            state <= OFF;
            tmr   <= OFF_LOAD;
            led   <= 1'b0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        OFF: begin
          if (tmr_done) begin
            // A trig on the restart cycle stands in for the queued event it would consume.
            if (pend_any || trig) begin
              state <= ON;
              tmr   <= ON_LOAD;
              led   <= 1'b1;
              if (pend_any && !trig) pending <= pending - 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tmr <= tmr - 1'b1;
            if (trig) begin
              if (pend_full) overflow <= 1'b1;
              else           pending  <= pending + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tmr   <= '0;
          led   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pulse_gen.sv
// Bench for led_pulse_gen: position-in-pulse reference model with an expected
// queue, directed literal scenarios, then randomized trig/clr/reset traffic.
module tb_led_pulse_gen;

  localparam int CNT_W  = 8;
  localparam int ON     = 4;
  localparam int OFF    = 3;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;
  localparam int PLEN   = ON + OFF;
  localparam int W      = 3 + PEND_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              trig;
  logic              clr;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Model state: m_pos is the cycle index inside the current pulse (-1 = idle).
  int m_pos;
  int m_q;
  bit m_ovf;

  led_pulse_gen #(
    .CNT_W     (CNT_W),
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .PEND_W    (PEND_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .trig    (trig),
    .clr     (clr),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] exp_word(input int pos, input int q, input bit ovf);
    logic l;
    logic b;
    l = (pos >= 0) && (pos < ON);
    b = (pos >= 0);
    return {l, b, q[PEND_W-1:0], ovf};
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or negedge rst) begin : model
    int pos;
    int q;
    int ev;
    bit ovf;
    if (!rst) begin
      m_pos <= -1;
      m_q   <= 0;
      m_ovf <= 1'b0;
      exp_q.delete();
    end else begin
      pos = m_pos;
      q   = m_q;
      ovf = m_ovf;
      if (clr) begin
        pos = -1;
        q   = 0;
        ovf = 1'b0;
      end else if (pos < 0) begin
        if (trig) pos = 0;
      end else if (pos == PLEN - 1) begin
        ev = q + (trig ? 1 : 0);
        if (ev > 0) begin
          pos = 0;
          q   = ev - 1;
        end else begin
          pos = -1;
        end
      end else begin
        pos = pos + 1;
        if (trig) begin
          if (q == PMAX) ovf = 1'b1;
          else           q   = q + 1;
        end
      end
      m_pos <= pos;
      m_q   <= q;
      m_ovf <= ovf;
      exp_q.push_back(exp_word(pos, q, ovf));
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic [W-1:0] a;
    logic [W-1:0] e;
    a = {led, busy, pending, overflow};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model", 32'(a), 32'(e));
    end else if (!rst) begin
      check("in_reset", 32'(a), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scenario(input string nm, input int n, input logic [31:0] trig_pat,
                          input logic [31:0] led_pat, input logic [31:0] busy_pat,
                          input logic [31:0] ovf_pat, input int pend_exp[32]);
    for (int i = 0; i < n; i++) begin
      trig = trig_pat[i];
      @(negedge clk);
      check({nm, "_led"},  32'(led),      32'(led_pat[i]));
      check({nm, "_busy"}, 32'(busy),     32'(busy_pat[i]));
      check({nm, "_pend"}, 32'(pending),  32'(pend_exp[i]));
      check({nm, "_ovf"},  32'(overflow), 32'(ovf_pat[i]));
    end
    trig = 1'b0;
  endtask

  task automatic async_reset_pulse();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_led",  32'(led),  32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int none[32];
    int queued[32];
    int ovfp[32];
    int density;
    none   = '{default: 0};
    queued = '{0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    ovfp   = '{0, 1, 2, 3, 3, 3, 3, 2, 2, 2, 2, 2, 2, 2, 1, 1,
               1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    rst  = 1'b0;
    trig = 1'b0;
    clr  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_out", 32'({led, busy, pending, overflow}), 32'd0);

    scenario("single",  10, 32'h1,  32'h0F,  32'h7F,   32'h0, none);
    scenario("queued",  16, 32'h3,  32'h78F, 32'h3FFF, 32'h0, queued);
    scenario("lastoff", 16, 32'h81, 32'h78F, 32'h3FFF, 32'h0, none);
    scenario("ovfl",    30, 32'h1F, 32'h1E3C78F, 32'h0FFFFFFF, 32'hFFFFFFF0, ovfp);

    // clr together with trig during ON flushes everything, overflow included
    trig = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    clr  = 1'b0;
    check("clr_out", 32'({led, busy, pending, overflow}), 32'd0);
    repeat (3) @(negedge clk);
    check("clr_stays_idle", 32'(busy), 32'd0);

    // reset asserted mid-ON
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    @(negedge clk);
    check("pre_rst_led", 32'(led), 32'd1);
    async_reset_pulse();

    // randomized traffic
    for (int blk = 0; blk < 12; blk++) begin
      density = $urandom_range(5, 90);
      for (int c = 0; c < 200; c++) begin
        trig = ($urandom_range(0, 99) < density);
        clr  = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 399) == 0) begin
          trig = 1'b0;
          clr  = 1'b0;
          async_reset_pulse();
        end else begin
          @(negedge clk);
        end
      end
    end
    trig = 1'b0;
    clr  = 1'b0;
    repeat (40) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
